// File: rtl/noise_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the noise table generator.
package noise_pkg;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t READY = 2'd2;

    // Adds two sign-extended operands and clamps to the signed range of a w-bit result.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = a + b;
        hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/noise_lfsr16.sv
// 16-bit right-shifting Galois LFSR with seed load; a zero seed falls back to the default.
module noise_lfsr16
    import noise_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // NOTE: assigning a default before any branch keeps always_comb free of inferred latches.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
        end else if (advance) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr_q <= LFSR_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/noise_table_gen.sv
// Loads a noise table from wide memory words, then adds a scaled, LFSR-indexed
// table entry to each accepted sample with saturation.
module noise_table_gen
    import noise_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MEM_W  = 64,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_load,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [MEM_W-1:0]  mem_data,
    output logic              done_wait,
    input  logic [15:0]       seed,
    input  logic              seed_load,
    input  logic [2:0]        shift,
    input  logic              en,
    input  logic [DATA_W-1:0] noise_in,
    input  logic              noise_in_valid,
    output logic [DATA_W-1:0] noise_out,
    output logic              noise_out_valid
);

    localparam int EPW   = MEM_W / DATA_W;
    localparam int WORDS = DEPTH / EPW;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]    cap_cnt_q, cap_cnt_d;
    logic                cap_valid_q, cap_valid_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   noise_out_q, noise_out_d;
    logic                noise_out_valid_q, noise_out_valid_d;

    logic signed [DATA_W-1:0] table_q [DEPTH];
    logic signed [DATA_W-1:0] tab_val;
    logic signed [DATA_W-1:0] noise_n;
    logic [15:0]              lfsr;
    logic                     accept;
    logic                     unused_lfsr_hi;

    assign accept = (state_q == READY) && en && noise_in_valid;

    noise_lfsr16 u_lfsr (
        .clk       (clk),
        .rstn      (rstn),
        .seed_load (seed_load),
        .seed      (seed),
        .advance   (accept),
        .lfsr      (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:IDX_W];

    // Reads are issued one cycle after entering LOAD; each word lands one cycle after
    // its read and is written the following edge, so capture trails issue by two.
    always_comb begin
        state_d     = state_q;
        iss_cnt_d   = iss_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        cap_valid_d = mem_rd_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = '0;
        case (state_q)
            IDLE, READY: begin
                if (start_load) begin
                    state_d   = LOAD;
                    iss_cnt_d = '0;
                    cap_cnt_d = '0;
                end
            end
            LOAD: begin
                if (iss_cnt_q != WORDS_C) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = ADDR_W'(iss_cnt_q);
                    iss_cnt_d  = iss_cnt_q + CNT_W'(1);
                end
                if (cap_valid_q) begin
                    cap_cnt_d = cap_cnt_q + CNT_W'(1);
                    if (cap_cnt_q == LAST_C) begin
                        state_d = READY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tab_val           = table_q[lfsr[IDX_W-1:0]];
        noise_n           = tab_val >>> shift;
        noise_out_d       = noise_out_q;
        noise_out_valid_d = accept;
        if (accept) begin
            noise_out_d = DATA_W'(sat_add(32'($signed(noise_in)), 32'(noise_n), DATA_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q           <= IDLE;
            iss_cnt_q         <= '0;
            cap_cnt_q         <= '0;
            cap_valid_q       <= 1'b0;
            mem_rd_q          <= 1'b0;
            mem_addr_q        <= '0;
            noise_out_q       <= '0;
            noise_out_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            iss_cnt_q         <= iss_cnt_d;
            cap_cnt_q         <= cap_cnt_d;
            cap_valid_q       <= cap_valid_d;
            mem_rd_q          <= mem_rd_d;
            mem_addr_q        <= mem_addr_d;
            noise_out_q       <= noise_out_d;
            noise_out_valid_q <= noise_out_valid_d;
        end
    end

    // NOTE: the table is left out of reset; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (rstn && state_q == LOAD && cap_valid_q) begin
            for (int b = 0; b < EPW; b++) begin
                table_q[IDX_W'(int'(cap_cnt_q) * EPW + b)] <= mem_data[b*DATA_W +: DATA_W];
            end
        end
    end

    assign mem_rd          = mem_rd_q;
    assign mem_addr        = mem_addr_q;
    assign done_wait       = (state_q == READY);
    assign noise_out       = noise_out_q;
    assign noise_out_valid = noise_out_valid_q;

endmodule

// File: tb/tb_noise_table_gen.sv
// Randomised and directed bench for noise_table_gen against a cycle-level behavioural model.
module tb_noise_table_gen;

    localparam int WORDS = 16;

    logic        clk = 1'b0;
    logic        rstn, start_load, mem_rd, done_wait, seed_load, en;
    logic        noise_in_valid, noise_out_valid;
    logic [7:0]  mem_addr, noise_in, noise_out;
    logic [63:0] mem_data;
    logic [15:0] seed;
    logic [2:0]  shift;

    logic [63:0] mem [WORDS];
    byte         ref_tab [128];
    logic [15:0] m_lfsr;
    bit          m_ready, m_loading;
    int          m_cnt;
    logic [7:0]  m_out;
    int          n_checks, n_pass;

    always #5 clk = ~clk;

    noise_table_gen dut (
        .clk             (clk),
        .rstn            (rstn),
        .start_load      (start_load),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .done_wait       (done_wait),
        .seed            (seed),
        .seed_load       (seed_load),
        .shift           (shift),
        .en              (en),
        .noise_in        (noise_in),
        .noise_in_valid  (noise_in_valid),
        .noise_out       (noise_out),
        .noise_out_valid (noise_out_valid)
    );

    // Synchronous memory: data for a read strobe appears the following cycle.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr[3:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic build_tab();
        for (int i = 0; i < 128; i++) ref_tab[i] = byte'(mem[i / 8] >> (8 * (i % 8)));
    endtask

    // One clock edge: predict from current inputs, advance, then compare at the negedge.
    task automatic cycle();
        bit         acc, rst, rd_exp;
        logic [7:0] exp_o;
        int         n, s;
        rst   = !rstn;
        acc   = !rst && m_ready && en && noise_in_valid;
        exp_o = m_out;
        if (acc) begin
            n = int'(ref_tab[m_lfsr[6:0]]) >>> shift;
            s = int'($signed(noise_in)) + n;
            if (s > 127) s = 127;
            else if (s < -128) s = -128;
            exp_o = 8'(s);
        end
        if (rst) begin
            exp_o     = 8'h00;
            m_ready   = 1'b0;
            m_loading = 1'b0;
            m_lfsr    = 16'hACE1;
        end else begin
            if (m_loading) begin
                m_cnt++;
                if (m_cnt == WORDS + 2) begin
                    m_loading = 1'b0;
                    m_ready   = 1'b1;
                end
            end else if (start_load) begin
                m_loading = 1'b1;
                m_cnt     = 0;
                m_ready   = 1'b0;
                build_tab();
            end
            if (seed_load) m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
            else if (acc) m_lfsr = lfsr_step(m_lfsr);
        end
        m_out  = exp_o;
        rd_exp = m_loading && m_cnt >= 1 && m_cnt <= WORDS;
        @(negedge clk);
        check("out_valid", noise_out_valid, acc);
        check("noise_out", noise_out, exp_o);
        check("done_wait", done_wait, m_ready);
        check("mem_rd", mem_rd, rd_exp);
        check("mem_addr", mem_addr, rd_exp ? 64'(m_cnt - 1) : 64'd0);
    endtask

    task automatic run_load();
        start_load = 1'b1;
        cycle();
        start_load = 1'b0;
        repeat (WORDS + 2) cycle();
        check("load_done", done_wait, 1'b1);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int w = 0; w < WORDS; w++) mem[w] = {8{v}};
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rstn = 1'b0; start_load = 1'b0; seed_load = 1'b0; seed = '0; shift = '0;
        en = 1'b0; noise_in = '0; noise_in_valid = 1'b0; mem_data = '0;
        m_lfsr = 16'hACE1; m_ready = 1'b0; m_loading = 1'b0; m_cnt = 0; m_out = '0;
        @(negedge clk);
        repeat (2) cycle();
        rstn = 1'b1;

        // Load timing and lane mapping: word w carries w in every lane.
        for (int w = 0; w < WORDS; w++) mem[w] = {8{8'(w)}};
        run_load();
        en = 1'b1; noise_in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            noise_in = 8'($urandom_range(0, 60));
            cycle();
        end

        // Gating: dropped samples in READY with en=0 and during the reload.
        en = 1'b0; seed = 16'h0001; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        repeat (3) cycle();
        for (int w = 0; w < WORDS; w++)
            for (int b = 0; b < 8; b++) mem[w][8*b +: 8] = 8'(8 * w + b);
        start_load = 1'b1;
        cycle();
        start_load = 1'b0; en = 1'b1;
        repeat (WORDS + 2) cycle();
        check("gate_ready", done_wait, 1'b1);
        noise_in = 8'h00; shift = 3'd0;
        cycle();
        check("idx_seq0", noise_out, 8'h01);
        cycle();
        check("idx_seq1", noise_out, 8'h00);

        // Saturation at both rails.
        en = 1'b0; fill_const(8'h7F);
        run_load();
        en = 1'b1; noise_in = 8'd100;
        cycle();
        check("sat_hi", noise_out, 8'h7F);
        en = 1'b0; fill_const(8'h80);
        run_load();
        en = 1'b1; noise_in = 8'h9C;
        cycle();
        check("sat_lo", noise_out, 8'h80);

        // Arithmetic shift of a negative entry.
        noise_in = 8'd5; shift = 3'd3;
        cycle();
        check("shift3", noise_out, 8'hF5);
        shift = 3'd7;
        cycle();
        check("shift7", noise_out, 8'h04);

        // Reset in the middle of a load, then a clean reload.
        en = 1'b0; shift = 3'd0; fill_const(8'h03);
        start_load = 1'b1;
        cycle();
        start_load = 1'b0;
        repeat (7) cycle();
        rstn = 1'b0;
        cycle();
        check("rst_mid_rd", mem_rd, 1'b0);
        check("rst_mid_out", noise_out, 8'h00);
        rstn = 1'b1;
        repeat (20) cycle();
        check("rst_idle", done_wait, 1'b0);
        run_load();
        en = 1'b1; noise_in = 8'd10;
        cycle();
        check("reload", noise_out, 8'd13);

        // Random traffic including reloads, reseeds and zero seeds.
        for (int w = 0; w < WORDS; w++) mem[w] = {$urandom, $urandom};
        run_load();
        for (int i = 0; i < 600; i++) begin
            en             = ($urandom_range(0, 3) != 0);
            noise_in_valid = ($urandom_range(0, 3) != 0);
            noise_in       = 8'($urandom);
            shift          = 3'($urandom);
            seed_load      = ($urandom_range(0, 19) == 0);
            seed           = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            start_load     = ($urandom_range(0, 99) == 0);
            if (start_load && !m_loading)
                for (int w = 0; w < WORDS; w++) mem[w] = {$urandom, $urandom};
            cycle();
        end
        start_load = 1'b0; seed_load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/noise_table_gen.md
Name: noise_table_gen

Overview:
Parametrised successor to the 128-entry noise wrapper. It loads a noise-distribution table of configurable depth from on-chip memory words, then adds one table-drawn noise value to each incoming channel sample. The table index comes from a seedable LFSR, and the noise is scaled at runtime with saturating addition. It sits between the channel model output and the receiver/ADC model. The table can be reloaded without a reset.

Parameters:
- DATA_W, 8: signed sample and noise width.
- MEM_W, 64: memory word width; must be a multiple of DATA_W.
- DEPTH, 128: table entries; power of two, 2..4096.
- ADDR_W, 8: mem_addr width; must satisfy 2^ADDR_W >= WORDS.
- Derived constants (not overridable):
  - EPW = MEM_W/DATA_W (entries per word).
  - WORDS = DEPTH/EPW.
  - IDX_W = log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- start_load  in  1  pulse; begins a table (re)load.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  word address.
- mem_data  in  MEM_W  read data, valid the cycle after mem_rd.
- done_wait  out  1  high while the table is loaded and the block is ready.
- seed  in  16  LFSR seed.
- seed_load  in  1  loads seed into the LFSR.
- shift  in  3  arithmetic right-shift applied to the noise value.
- en  in  1  noise enable.
- noise_in  in  DATA_W  signed input sample.
- noise_in_valid  in  1  input sample valid.
- noise_out  out  DATA_W  signed noisy sample.
- noise_out_valid  out  1  output valid.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - state=IDLE.
  - mem_rd=0, mem_addr=0, done_wait=0, noise_out=0, noise_out_valid=0.
  - LFSR=16'hACE1.
  - Table contents are not cleared.
- FSM states are IDLE, LOAD and READY.
  - IDLE -> LOAD on start_load.
  - LOAD -> READY after the last word is captured.
  - READY -> LOAD on start_load; done_wait drops the next cycle.
  - start_load during LOAD is ignored.
- Load timing (cycle 0 = edge that samples start_load):
  - mem_rd is high for exactly WORDS consecutive cycles, starting at cycle 1.
  - mem_addr runs 0..WORDS-1, one address per cycle.
  - mem_data for the read in cycle k is captured at the end of cycle k+1.
  - Word w, lane b (bits b*DATA_W upward, LSB lane first) -> entry w*EPW+b.
  - done_wait rises at cycle WORDS+2 and stays high in READY.
  - mem_addr returns to 0 when mem_rd deasserts.
- Reset mid-load returns to IDLE. A new start_load is then needed; partial table contents are undefined.
- Generation: a sample is accepted when state=READY, en=1 and noise_in_valid=1.
  - idx = LFSR[IDX_W-1:0] (current value).
  - n = table[idx] >>> shift (sign-preserving).
  - sum = noise_in + n, computed at DATA_W+1 bits.
  - noise_out = sum saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Latency: noise_out and noise_out_valid are registered, one cycle after acceptance.
  - noise_out_valid=0 on cycles with no acceptance.
  - noise_out holds its last value when not valid.
- Samples with noise_in_valid=1 outside READY or with en=0 are dropped; no output, no LFSR advance.
- LFSR: 16-bit Galois, right shift. If lsb=1 then next = (L>>1)^16'hB400, else next = L>>1.
  - It advances only on an accepted sample.
  - seed_load loads seed, or 16'hACE1 if seed==0. It has priority over an advance in the same cycle.
  - seed_load is honoured in any state.
- Simultaneous start_load and accepted sample in READY: the sample completes normally; subsequent samples are dropped until READY again.

Decomposition:
- Package noise_pkg: LFSR_TAPS=16'hB400, LFSR_DEFAULT=16'hACE1, state enum {IDLE, LOAD, READY}, saturating-add function.
- Sub-module noise_lfsr16 (seed/load/advance, 16-bit state output). The table and FSM stay in noise_table_gen.

Test Plan:
All scenarios use default parameters (WORDS=16).
1. Load timing: start_load pulse; memory returns word w = {8{8'(w)}} -> mem_rd high cycles 1..16, addr 0..15; done_wait rises at cycle 18; entry 8w+b = w.
2. Index sequence: table entry i = i; seed_load with seed=16'h0001, shift=0, en=1; noise_in=0 on two consecutive cycles -> noise_out 1 then 0 (LFSR 0x0001 -> 0xB400, idx 0x00).
3. Saturation: table all 8'h7F, noise_in=100, shift=0 -> noise_out=127. Table all 8'h80, noise_in=-100 -> noise_out=-128.
4. Shift: table all 8'h80, shift=3, noise_in=5 -> noise_out=-11. Then shift=7 -> noise_out=4.
5. Gating: noise_in_valid=1 with en=0, then en=1 before load completes -> noise_out_valid stays 0 and the LFSR is unchanged (checked via test 2 sequence afterwards).
6. Reset mid-load: rstn=0 at cycle 8 of a load -> mem_rd=0, done_wait=0, state IDLE. A reload with all 8'h03 and noise_in=10 -> noise_out=13.
